vector_k_search: RTL and testbench
==================================

Name: vector_k_search

Overview:
- Search engine that sits directly downstream of the AXI register front-end.
- Consumes the 64-bit word write port and the start pulse from that front-end; returns busy, winner_id and max_score to it.
- Holds NUM_VEC vectors in an internal word memory. Slot 0 is the query vector; slots 1..NUM_VEC-1 are candidates.
- On start, computes the signed int8 dot product of the query with every candidate and reports the best match.

Parameters:
- NUM_VEC, 256: number of vector slots, including query slot 0.
- WORDS_PER_VEC, 4: 64-bit words per vector (32 int8 elements).
- ELEM_W, 8: element width; signed two's complement, 8 elements per word.

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  asynchronous active-low reset
- write_addr  in  10  word address; slot = addr/WORDS_PER_VEC, word = addr%WORDS_PER_VEC
- write_data_64  in  64  packed elements, element 0 in bits [7:0]
- write_en  in  1  single-cycle word write strobe
- start_search  in  1  single-cycle start pulse
- busy  out  1  search in progress
- winner_id  out  8  slot index of best candidate
- max_score  out  32  signed score of winner
- done  out  1  one-cycle pulse when results update
- wr_drop  out  1  sticky flag: a write arrived while busy

Behaviour:
- Reset (async, any state): busy=0, done=0, wr_drop=0, winner_id=0, max_score=0, FSM=IDLE, accumulators cleared. Memory contents are not reset.
- Memory: 1024x64, synchronous write, synchronous read with 1-cycle latency.
- Writes: accepted when write_en=1 and busy=0. A write with busy=1 is dropped and sets wr_drop. wr_drop clears only on reset.
- FSM states: IDLE, LOAD_Q, SCAN, FINISH.
  - IDLE: start_search=1 moves to LOAD_Q; busy=1 from the next edge.
  - LOAD_Q: reads words 0..3 into the query register.
  - SCAN: issues one read per cycle, words 4..1023, back-to-back with no bubbles; LOAD_Q and SCAN issue continuously.
  - FINISH: entered after the last accumulate; updates the outputs.
- start_search while busy is ignored.
- Pipeline: issue address (t), data returns (t+1), 8-lane MAC added to accumulator (t+2), compare on the last word of a vector (t+3).
- Latency: busy high for exactly NUM_VEC*WORDS_PER_VEC+4 cycles, i.e. 1028 in the default config.
  - winner_id, max_score and done update on the same edge busy falls.
- Arithmetic:
  - Products are 16-bit signed; the per-word sum is sign-extended to 32 bits; the accumulator is 32-bit signed with no saturation (cannot overflow at the defaults).
- Selection:
  - Running best is initialised to the first candidate (slot 1) unconditionally.
  - A later candidate replaces it only if strictly greater (signed), so ties keep the lowest slot index.
- Output hold: outputs keep the previous search's results throughout a search. Running best is internal state only.
- Reset mid-scan aborts the search; a new start is required.

Optional Feature:
- VK_CYCLE_CNT_EN defined:
  - Adds output scan_cycles (16 bits, reset 0).
  - Counts cycles while busy=1 and is cleared at search start.
  - Holds its value after done; reads 1028 after a default search.
- Not defined: port and counter absent; all other behaviour identical.

Decomposition:
- Package vk_pkg:
  - ELEM_W, LANES=8, ADDR_W=10, SCORE_W=32.
  - FSM state enum.
  - Function slot_of(addr).
- Sub-module vk_dot8:
  - 8-lane signed int8 multiply plus adder tree, one registered stage.
  - Produces the per-word partial sum.

Test Plan:
- Reset -> busy=0, done=0, wr_drop=0, winner_id=0, max_score=0.
- Query all 0x01, slot 7 all 0x02, other candidates zero, start -> busy high 1028 cycles, winner_id=7, max_score=64, done pulses once.
- Slots 3 and 9 both all 0x02, query all 0x01 -> winner_id=3, max_score=64 (tie keeps lower index).
- Query all 0x01, every candidate all 0xFF -> winner_id=1, max_score=0xFFFFFFE0 (-32).
- Second start and a write at cycle 100 of a search -> start ignored, write dropped, wr_drop=1, memory word unchanged, results as if no write.
- Assert reset at cycle 500 of a search -> busy=0 immediately, outputs 0. Re-start without rewriting memory -> previous correct result reproduced.

Source files
------------

// File: rtl/vk_pkg.sv
// Shared types, sizing and address helpers for the vector_k_search engine.
package vk_pkg;

    localparam int NUM_VEC       = 256;
    localparam int WORDS_PER_VEC = 4;
    localparam int ELEM_W        = 8;
    localparam int LANES         = 8;
    localparam int ADDR_W        = 10;
    localparam int SCORE_W       = 32;
    localparam int WORD_W        = LANES * ELEM_W;
    localparam int PROD_W        = 2 * ELEM_W;
    localparam int SLOT_W        = 8;
    localparam int WSEL_W        = 2;
    localparam int TOTAL_WORDS   = NUM_VEC * WORDS_PER_VEC;
    localparam int CNT_W         = 11;

    // Cycle-count landmarks measured from the first LOAD_Q cycle.
    localparam logic [CNT_W-1:0]  QLOAD_END = CNT_W'(WORDS_PER_VEC - 1);
    localparam logic [CNT_W-1:0]  ISSUE_END = CNT_W'(TOTAL_WORDS);
    localparam logic [CNT_W-1:0]  SCAN_END  = CNT_W'(TOTAL_WORDS + 2);
    localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(WORDS_PER_VEC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_Q,
        ST_SCAN,
        ST_FINISH
    } vk_state_e;

    function automatic logic [SLOT_W-1:0] slot_of(input logic [ADDR_W-1:0] addr);
        return SLOT_W'(addr / WORDS_PER_VEC);
    endfunction

    function automatic logic [WSEL_W-1:0] word_of(input logic [ADDR_W-1:0] addr);
        return WSEL_W'(addr % WORDS_PER_VEC);
    endfunction

endpackage

// File: rtl/vector_k_search_if.sv
// Front-end <-> search engine bus: word writes and start in, status and results out.
// scan_cycles exists only when VK_CYCLE_CNT_EN is defined.
interface vector_k_search_if;
    import vk_pkg::*;

    logic [ADDR_W-1:0]  write_addr;
    logic [WORD_W-1:0]  write_data_64;
    logic               write_en;
    logic               start_search;
    logic               busy;
    logic [SLOT_W-1:0]  winner_id;
    logic [SCORE_W-1:0] max_score;
    logic               done;
    logic               wr_drop;
`ifdef VK_CYCLE_CNT_EN
    logic [15:0]        scan_cycles;
`endif

    modport master (
        output write_addr, write_data_64, write_en, start_search,
`ifdef VK_CYCLE_CNT_EN
        input  scan_cycles,
`endif
        input  busy, winner_id, max_score, done, wr_drop
    );

    modport slave (
        input  write_addr, write_data_64, write_en, start_search,
`ifdef VK_CYCLE_CNT_EN
        output scan_cycles,
`endif
        output busy, winner_id, max_score, done, wr_drop
    );

endinterface

// File: rtl/vk_dot8.sv
// 8-lane signed int8 dot product of two 64-bit words, sign-extended to the score width.
// Latency 1 cycle; no backpressure, a result is produced for every valid input.
module vk_dot8
    import vk_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_vld,
    input  logic [WORD_W-1:0]         a_dat,
    input  logic [WORD_W-1:0]         b_dat,
    output logic                      out_vld,
    output logic signed [SCORE_W-1:0] sum_dat
);

    logic signed [PROD_W-1:0]  prod [LANES];
    logic signed [SCORE_W-1:0] sum_d, sum_q;
    logic                      vld_d, vld_q;

    always_comb begin
        sum_d = '0;
        vld_d = in_vld;
        for (int i = 0; i < LANES; i++) begin
            prod[i] = PROD_W'($signed(a_dat[i*ELEM_W +: ELEM_W])) *
                      PROD_W'($signed(b_dat[i*ELEM_W +: ELEM_W]));
            sum_d   = sum_d + SCORE_W'(prod[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            vld_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            vld_q <= vld_d;
        end
    end

    assign out_vld = vld_q;
    assign sum_dat = sum_q;

endmodule

// File: rtl/vector_k_search.sv
// Best-match search: dot product of query slot 0 against slots 1..NUM_VEC-1, reports the max.
// Busy for TOTAL_WORDS+4 cycles per search; writes while busy are dropped (wr_drop), no stall.
// Define VK_CYCLE_CNT_EN to add the scan_cycles busy-cycle counter.
module vector_k_search
    import vk_pkg::*;
(
    input  logic              s_axi_aclk,
    input  logic              s_axi_aresetn,
    vector_k_search_if.slave  bus
);

    logic [WORD_W-1:0]         mem [TOTAL_WORDS];
    logic [WORD_W-1:0]         mem_rdata_q;

    vk_state_e                 state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      wr_drop_q, wr_drop_d;
    logic [SLOT_W-1:0]         winner_q, winner_d;
    logic signed [SCORE_W-1:0] score_q, score_d;

    logic [WORD_W-1:0]         query_q [WORDS_PER_VEC];
    logic [WORD_W-1:0]         query_d [WORDS_PER_VEC];
    logic                      rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0]         rd_addr1_q, rd_addr1_d;
    logic [ADDR_W-1:0]         addr2_q, addr2_d;
    logic signed [SCORE_W-1:0] acc_q, acc_d;
    logic                      acc_vld_q, acc_vld_d;
    logic [SLOT_W-1:0]         acc_slot_q, acc_slot_d;
    logic signed [SCORE_W-1:0] best_q, best_d;
    logic [SLOT_W-1:0]         best_id_q, best_id_d;

    logic                      issue;
    logic                      wr_acc;
    logic [ADDR_W-1:0]         rd_addr;
    logic                      dot_in_vld;
    logic [WORD_W-1:0]         query_sel;
    logic                      psum_vld;
    logic signed [SCORE_W-1:0] psum_dat;

`ifdef VK_CYCLE_CNT_EN
    logic [15:0]               cyc_q, cyc_d;
`endif

    // LOAD_Q and SCAN share one address counter, so the read stream has no gap.
    assign issue   = ((state_q == ST_LOAD_Q) || (state_q == ST_SCAN)) && (cnt_q < ISSUE_END);
    assign rd_addr = cnt_q[ADDR_W-1:0];
    assign wr_acc  = bus.write_en && !busy_q;

    always_ff @(posedge s_axi_aclk) begin
        if (wr_acc) begin
            mem[bus.write_addr] <= bus.write_data_64;
        end
        if (issue) begin
            mem_rdata_q <= mem[rd_addr];
        end
    end

    assign dot_in_vld = rd_vld_q && (slot_of(rd_addr1_q) != '0);
    assign query_sel  = query_q[word_of(rd_addr1_q)];

    vk_dot8 u_dot8 (
        .clk     (s_axi_aclk),
        .rst_n   (s_axi_aresetn),
        .in_vld  (dot_in_vld),
        .a_dat   (mem_rdata_q),
        .b_dat   (query_sel),
        .out_vld (psum_vld),
        .sum_dat (psum_dat)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_drop_d  = wr_drop_q | (bus.write_en & busy_q);
        winner_d   = winner_q;
        score_d    = score_q;
        query_d    = query_q;
        rd_vld_d   = issue;
        rd_addr1_d = rd_addr;
        addr2_d    = rd_addr1_q;
        acc_d      = acc_q;
        acc_vld_d  = 1'b0;
        acc_slot_d = acc_slot_q;
        best_d     = best_q;
        best_id_d  = best_id_q;
`ifdef VK_CYCLE_CNT_EN
        cyc_d      = busy_q ? cyc_q + 16'd1 : cyc_q;
`endif

        if (rd_vld_q && (slot_of(rd_addr1_q) == '0)) begin
            query_d[word_of(rd_addr1_q)] = mem_rdata_q;
        end

        if (psum_vld) begin
            if (word_of(addr2_q) == '0) begin
                acc_d = psum_dat;
            end else begin
                acc_d = acc_q + psum_dat;
            end
            acc_vld_d  = (word_of(addr2_q) == LAST_WORD);
            acc_slot_d = slot_of(addr2_q);
        end

        // Slot 1 seeds the running best; strict > keeps the lowest slot on ties.
        if (acc_vld_q && ((acc_slot_q == SLOT_W'(1)) || (acc_q > best_q))) begin
            best_d    = acc_q;
            best_id_d = acc_slot_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_search) begin
                    state_d = ST_LOAD_Q;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
`ifdef VK_CYCLE_CNT_EN
                    cyc_d   = '0;
`endif
                end
            end
            ST_LOAD_Q: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == QLOAD_END) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SCAN_END) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                winner_d = best_id_q;
                score_d  = best_q;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_drop_q  <= 1'b0;
            winner_q   <= '0;
            score_q    <= '0;
            query_q    <= '{default: '0};
            rd_vld_q   <= 1'b0;
            rd_addr1_q <= '0;
            addr2_q    <= '0;
            acc_q      <= '0;
            acc_vld_q  <= 1'b0;
            acc_slot_q <= '0;
            best_q     <= '0;
            best_id_q  <= '0;
`ifdef VK_CYCLE_CNT_EN
            cyc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_drop_q  <= wr_drop_d;
            winner_q   <= winner_d;
            score_q    <= score_d;
            query_q    <= query_d;
            rd_vld_q   <= rd_vld_d;
            rd_addr1_q <= rd_addr1_d;
            addr2_q    <= addr2_d;
            acc_q      <= acc_d;
            acc_vld_q  <= acc_vld_d;
            acc_slot_q <= acc_slot_d;
            best_q     <= best_d;
            best_id_q  <= best_id_d;
`ifdef VK_CYCLE_CNT_EN
            cyc_q      <= cyc_d;
`endif
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wr_drop   = wr_drop_q;
    assign bus.winner_id = winner_q;
    assign bus.max_score = score_q;
`ifdef VK_CYCLE_CNT_EN
    assign bus.scan_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_vector_k_search.sv
// Directed bench for vector_k_search: model memory computes each expected winner, a scoreboard
// queue holds it until done, immediate assertions compare at every check point.
module tb_vector_k_search;
    import vk_pkg::*;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] sc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb_q[$];
    logic [63:0] model_mem [1024];
    logic [7:0]  prev_id;
    logic [31:0] prev_sc;

    vector_k_search_if bus();

    vector_k_search dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_word(input int addr, input logic [63:0] data);
        bus.write_addr    = 10'(addr);
        bus.write_data_64 = data;
        bus.write_en      = 1'b1;
        model_mem[addr]   = data;
        @(negedge clk);
        bus.write_en      = 1'b0;
    endtask

    function automatic exp_t model_best();
        exp_t e;
        int   best;
        int   s;
        logic signed [7:0] qa;
        logic signed [7:0] ca;
        best = 0;
        e    = '0;
        for (int v = 1; v < 256; v++) begin
            s = 0;
            for (int w = 0; w < 4; w++) begin
                for (int l = 0; l < 8; l++) begin
                    qa = model_mem[w][l*8 +: 8];
                    ca = model_mem[v*4 + w][l*8 +: 8];
                    s  = s + int'(qa) * int'(ca);
                end
            end
            if (v == 1 || s > best) begin
                best = s;
                e.id = 8'(v);
            end
        end
        e.sc = 32'(best);
        return e;
    endfunction

    // Runs one search; at busy cycle inject (1-based) a dropped write and a second start are driven.
    task automatic run_search(input string tag, input int inject);
        exp_t e;
        exp_t got;
        int   blen;
        int   dcnt;
        e = model_best();
        sb_q.push_back(e);
        @(negedge clk);
        bus.start_search = 1'b1;
        @(negedge clk);
        bus.start_search = 1'b0;
        blen = 0;
        dcnt = 0;
        while (bus.busy === 1'b1 && blen < 2000) begin
            blen++;
            if (bus.done === 1'b1) dcnt++;
            if (blen == 10) begin
                chk({tag, "_hold_id"}, 32'(bus.winner_id), 32'(prev_id));
                chk({tag, "_hold_score"}, bus.max_score, prev_sc);
            end
            if (blen == inject) begin
                bus.write_addr    = 10'd20;
                bus.write_data_64 = 64'h7F7F7F7F7F7F7F7F;
                bus.write_en      = 1'b1;
                bus.start_search  = 1'b1;
            end else begin
                bus.write_en      = 1'b0;
                bus.start_search  = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, "_busy_len"}, 32'(blen), 32'd1028);
        chk({tag, "_done_at_fall"}, 32'(bus.done), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (bus.done === 1'b1) begin
                dcnt++;
                if (sb_q.size() != 0) begin
                    got = sb_q.pop_front();
                    chk({tag, "_winner"}, 32'(bus.winner_id), 32'(got.id));
                    chk({tag, "_score"}, bus.max_score, got.sc);
                end
            end
            @(negedge clk);
        end
        chk({tag, "_done_count"}, 32'(dcnt), 32'd1);
        chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
`ifdef VK_CYCLE_CNT_EN
        chk({tag, "_scan_cycles"}, 32'(bus.scan_cycles), 32'd1028);
`endif
        prev_id = e.id;
        prev_sc = e.sc;
    endtask

    initial begin
        checks            = 0;
        failures          = 0;
        prev_id           = '0;
        prev_sc           = '0;
        rst_n             = 1'b0;
        bus.write_addr    = '0;
        bus.write_data_64 = '0;
        bus.write_en      = 1'b0;
        bus.start_search  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_wr_drop", 32'(bus.wr_drop), 32'd0);
        chk("rst_winner", 32'(bus.winner_id), 32'd0);
        chk("rst_score", bus.max_score, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int a = 0; a < 1024; a++) wr_word(a, 64'h0);

        // Single clear winner.
        for (int w = 0; w < 4; w++) wr_word(w, 64'h0101010101010101);
        for (int w = 0; w < 4; w++) wr_word(7*4 + w, 64'h0202020202020202);
        run_search("single", -1);

        // Tie between slots 3 and 9.
        for (int w = 0; w < 4; w++) wr_word(7*4 + w, 64'h0);
        for (int w = 0; w < 4; w++) wr_word(3*4 + w, 64'h0202020202020202);
        for (int w = 0; w < 4; w++) wr_word(9*4 + w, 64'h0202020202020202);
        run_search("tie", -1);

        // All candidates negative: slot 1 seeds and survives.
        for (int a = 4; a < 1024; a++) wr_word(a, 64'hFFFFFFFFFFFFFFFF);
        run_search("neg", -1);

        // Write and start during a search are ignored; a second search proves memory untouched.
        run_search("drop", 100);
        chk("drop_wr_drop", 32'(bus.wr_drop), 32'd1);
        run_search("drop_rerun", -1);
        chk("drop_wr_drop_sticky", 32'(bus.wr_drop), 32'd1);

        // Reset mid-search, then restart on the retained memory.
        wr_word(200*4 + 2, 64'h0303030303030303);
        @(negedge clk);
        bus.start_search = 1'b1;
        @(negedge clk);
        bus.start_search = 1'b0;
        repeat (499) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_wr_drop", 32'(bus.wr_drop), 32'd0);
        chk("abort_winner", 32'(bus.winner_id), 32'd0);
        chk("abort_score", bus.max_score, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        prev_id = '0;
        prev_sc = '0;
        @(negedge clk);
        run_search("restart", -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
